// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_tx
// Description : Serial frame transmitter. Accepts a payload word over a
//               valid/ready handshake and shifts out, one bit per clock, a
//               sync pattern (MSB-first), the payload (MSB-first) and a run
//               of forced-low gap bits.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_tx #(
    parameter int                SYNC_W     = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 4'b1101,
    parameter int                DATA_W     = 8,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              outp,
    output logic              busy,
    output logic              frame_done
);

    // Counter must hold the longest phase length without wrapping.
    localparam int c_MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int c_MAX_B = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
    localparam int c_MAX   = (c_MAX_B > 1) ? c_MAX_B : 1;
    localparam int c_CNT_W = $clog2(c_MAX) + 1;
    localparam int c_SR_W  = SYNC_W + DATA_W;

    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_W);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_DATA_PEN  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SR_W-1:0]    r_sr;
    logic                 r_ready;
    logic                 r_outp;
    logic                 r_busy;
    logic                 r_fd;
    logic [c_SR_W-1:0]    w_load;

    // Sync and payload share one shift register so every bit is just its MSB.
    assign w_load = {SYNC_PAT, data_in};

    // Frame sequencer: phase counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_ready <= 1'b0;
            r_outp  <= 1'b0;
            r_busy  <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_outp <= 1'b0;
                    r_busy <= 1'b0;
                    r_fd   <= 1'b0;
                    if (data_valid && r_ready) begin
                        // First sync bit goes out on the acceptance edge itself.
                        r_sr    <= w_load << 1;
                        r_outp  <= w_load[c_SR_W-1];
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_cnt   <= c_ONE;
                        r_state <= S_SYNC;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_SYNC: begin
                    r_outp <= r_sr[c_SR_W-1];
                    r_sr   <= r_sr << 1;
                    if (r_cnt == c_SYNC_LAST) begin
                        // This edge already emits the payload MSB.
                        r_cnt   <= c_ONE;
                        r_fd    <= (DATA_W == 1);
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_DATA_LAST) begin
                        r_outp <= 1'b0;
                        r_fd   <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= c_ONE;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_outp <= r_sr[c_SR_W-1];
                        r_sr   <= r_sr << 1;
                        r_fd   <= (r_cnt == c_DATA_PEN);
                        r_cnt  <= r_cnt + c_ONE;
                    end
                end
                S_GAP: begin
                    r_outp <= 1'b0;
                    if (r_cnt == c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_ready = r_ready;
    assign outp       = r_outp;
    assign busy       = r_busy;
    assign frame_done = r_fd;

endmodule
`default_nettype wire
